// File: rtl/sddac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sddac_pkg: widths, loop constants and arithmetic helpers for sddac_mod2   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package sddac_pkg;

  localparam int DATA_W  = 18;
  localparam int ACC_W   = DATA_W + 4;
  localparam int SUM_W   = ACC_W + 2;
  localparam int FS_INT  = 2 ** (DATA_W - 1);
  localparam int CLIP_INT = (FS_INT * 3) / 4;
  localparam int ACC_MAX = 2 ** (ACC_W - 1) - 1;
  localparam int ACC_MIN = -(2 ** (ACC_W - 1));

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  localparam sample_t CLIP     = sample_t'(CLIP_INT);
  localparam sample_t CLIP_NEG = sample_t'(-CLIP_INT);
  localparam acc_t    FS       = acc_t'(FS_INT);
  localparam acc_t    FS_NEG   = acc_t'(-FS_INT);

  function automatic acc_t sext(input sample_t s);
    return {{(ACC_W - DATA_W){s[DATA_W-1]}}, s};
  endfunction

  function automatic sample_t clamp(input sample_t s);
    if (s > CLIP)
      return CLIP;
    else if (s < CLIP_NEG)
      return CLIP_NEG;
    else
      return s;
  endfunction

  // Two guard bits cover a + b - fb for any three ACC_W operands.
  function automatic acc_t sat(input sum_t v);
    if (v > sum_t'(ACC_MAX))
      return acc_t'(ACC_MAX);
    else if (v < sum_t'(ACC_MIN))
      return acc_t'(ACC_MIN);
    else
      return v[ACC_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sddac_integrator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sddac_integrator: saturating accumulator q <= sat(a + b - fb)             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sddac_integrator
  import sddac_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  acc_t a_i,
  input  acc_t b_i,
  input  acc_t fb_i,
  output acc_t q_o,
  output acc_t d_o
);

  acc_t int_q;
  acc_t int_d;

  always_comb begin
    int_d = sat(sum_t'(a_i) + sum_t'(b_i) - sum_t'(fb_i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      int_q <= '0;
    else
      int_q <= int_d;
  end

  assign q_o = int_q;
  assign d_o = int_d;

endmodule
`default_nettype wire

// File: rtl/sddac_mod2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sddac_mod2: 2nd-order sigma-delta modulator with ZOH sample input         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sddac_mod2
  import sddac_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 2083
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              underrun_clr,
  output logic              underrun,
  output logic              dac_out
);

  localparam int             CNT_W    = $clog2(SAMPLE_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  sample_t          hold_q, hold_d;
  logic             underrun_q, underrun_d;
  logic             dac_q, dac_d;

  logic strobe;
  acc_t x;
  acc_t fb;
  acc_t int1_q, int2_q, int2_d;
  acc_t int1_next_unused;

  assign strobe = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d      = strobe ? '0 : cnt_q + CNT_W'(1);
    hold_d     = hold_q;
    underrun_d = underrun_q;
    if (strobe && sample_valid)
      hold_d = sample_t'(sample_in);
    // A missed strobe must win over a coincident clear.
    if (strobe && !sample_valid)
      underrun_d = 1'b1;
    else if (underrun_clr)
      underrun_d = 1'b0;
  end

  assign x  = sext(clamp(hold_q));
  assign fb = dac_q ? FS : FS_NEG;

  sddac_integrator u_int1 (
    .clk   (clk),
    .reset (reset),
    .a_i   (int1_q),
    .b_i   (x),
    .fb_i  (fb),
    .q_o   (int1_q),
    .d_o   (int1_next_unused)
  );

  sddac_integrator u_int2 (
    .clk   (clk),
    .reset (reset),
    .a_i   (int2_q),
    .b_i   (int1_q),
    .fb_i  (fb),
    .q_o   (int2_q),
    .d_o   (int2_d)
  );

  // Quantize the value being loaded so the output tracks int2 without a lag.
  assign dac_d = ~int2_d[ACC_W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      hold_q     <= '0;
      underrun_q <= 1'b0;
      dac_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      underrun_q <= underrun_d;
      dac_q      <= dac_d;
    end
  end

  assign sample_ready = strobe;
  assign underrun     = underrun_q;
  assign dac_out      = dac_q;

endmodule
`default_nettype wire

// File: tb/tb_sddac_mod2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sddac_mod2: random and directed stimulus against an integer model      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sddac_mod2;

  localparam int     P     = 16;
  localparam longint FSV   = 131072;
  localparam longint CLIPV = 98304;
  localparam longint AMAX  = 2097151;
  localparam longint AMIN  = -2097152;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [17:0] sample_in;
  logic               sample_valid;
  logic               sample_ready;
  logic               underrun_clr;
  logic               underrun;
  logic               dac_out;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: plain integers, cycle index kept modulo the period.
  int     m_cyc;
  longint m_hold, m_i1, m_i2;
  bit     m_dac, m_unr;

  sddac_mod2 #(.SAMPLE_PERIOD(P)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .underrun_clr (underrun_clr),
    .underrun     (underrun),
    .dac_out      (dac_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic longint satv(input longint v);
    return (v > AMAX) ? AMAX : (v < AMIN) ? AMIN : v;
  endfunction

  function automatic longint clipv(input longint v);
    return (v > CLIPV) ? CLIPV : (v < -CLIPV) ? -CLIPV : v;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_hold = 0; m_i1 = 0; m_i2 = 0; m_dac = 0; m_unr = 0;
  endtask

  function automatic bit m_ready();
    return (m_cyc % P) == (P - 1);
  endfunction

  task automatic model_edge();
    longint x, fb, n1, n2;
    bit     take;
    take = m_ready();
    x    = clipv(m_hold);
    fb   = m_dac ? FSV : -FSV;
    n1   = satv(m_i1 + x - fb);
    n2   = satv(m_i2 + m_i1 - fb);
    m_i1 = n1;
    m_i2 = n2;
    m_dac = (n2 >= 0);
    if (take && sample_valid) m_hold = longint'(sample_in);
    if (take && !sample_valid) m_unr = 1;
    else if (underrun_clr) m_unr = 0;
    m_cyc++;
  endtask

  // One clock: model advances on the edge, DUT is compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    chk("dac", dac_out, m_dac);
    chk("ready", sample_ready, m_ready());
    chk("underrun", underrun, m_unr);
  endtask

  task automatic run(input int n, output int ones, output int readies);
    ones = 0; readies = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      ones    += dac_out;
      readies += sample_ready;
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!sample_ready && k < 2 * P) begin
      cyc();
      k++;
    end
    if (!sample_ready) chk("wait_ready_timeout", 0, 1);
  endtask

  task automatic density(input string tag, input longint s, input int lo, input int hi);
    int ones, rd;
    sample_in = 18'(s);
    run(64, ones, rd);
    run(4096, ones, rd);
    chk(tag, (ones >= lo) && (ones <= hi), 1);
  endtask

  initial begin
    int ones, rd, k;
    reset = 1'b1; sample_in = '0; sample_valid = 1'b0; underrun_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_dac", dac_out, 0);
    chk("rst_ready", sample_ready, 0);
    chk("rst_underrun", underrun, 0);
    reset = 1'b0;

    // Zero input: idle tone at half density, strobe every P clocks.
    sample_valid = 1'b1;
    run(64, ones, rd);
    run(1024, ones, rd);
    chk("zero_density", (ones >= 510) && (ones <= 514), 1);
    chk("zero_ready_count", rd, 1024 / P);

    // Random samples, valid and clear, tracked cycle by cycle.
    for (int i = 0; i < 600; i++) begin
      sample_in    = 18'($urandom);
      sample_valid = ($urandom_range(0, 3) != 0);
      underrun_clr = ($urandom_range(0, 7) == 0);
      cyc();
    end
    sample_valid = 1'b1; underrun_clr = 1'b1;
    cyc();
    underrun_clr = 1'b0;

    // Step 0 -> +FS/2 aligned to a strobe.
    sample_in = '0;
    run(4 * P, ones, rd);
    wait_ready();
    density("dens_pos_half", 65536, 3052, 3092);
    density("dens_neg_half", -65536, 1004, 1044);
    density("dens_over_clip", 131071, 3564, 3604);
    density("dens_clip", 98304, 3564, 3604);

    // Missed strobe, clear, then clear coincident with a new miss.
    sample_in = 18'(65536);
    wait_ready();
    sample_valid = 1'b0;
    cyc();
    chk("unr_set", underrun, 1);
    sample_valid = 1'b1;
    sample_in = 18'(-65536);
    run(3, ones, rd);
    chk("unr_sticky", underrun, 1);
    underrun_clr = 1'b1;
    cyc();
    underrun_clr = 1'b0;
    chk("unr_clr", underrun, 0);
    wait_ready();
    sample_valid = 1'b0; underrun_clr = 1'b1;
    cyc();
    sample_valid = 1'b1; underrun_clr = 1'b0;
    chk("unr_set_wins", underrun, 1);

    // Asynchronous reset while dac_out is high.
    k = 0;
    while (!dac_out && k < 64) begin cyc(); k++; end
    chk("pre_rst_dac_high", dac_out, 1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("async_dac", dac_out, 0);
    chk("async_ready", sample_ready, 0);
    chk("async_underrun", underrun, 0);
    repeat (3) cyc();
    reset = 1'b0;
    k = 0;
    while (!sample_ready && k < 2 * P) begin cyc(); k++; end
    chk("first_ready_edges", k, P - 1);
    run(3 * P, ones, rd);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
